pipe_stage_skid: RTL

//  Parametrised pipeline stage register, successor to the fixed MEM/WB register.

---
 rtl/pipe_stage_skid_if.sv | 32 +++
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Purpose: handshake + instruction bundle carried between two pipeline stages.
//   master drives valid and the payload fields, slave drives ready.
// Signals:
//   valid  master->slave  bundle valid
//   ready  slave->master  receiver can accept
//   a3     destination register index (A3_W)
//   pc8    PC+8 (DATA_W)
//   ao     ALU result (DATA_W)
//   dm     memory read data (DATA_W)
//   instr  instruction word (DATA_W)
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int A3_W   = 5
);
    logic              valid;
    logic              ready;
    logic [A3_W-1:0]   a3;
    logic [DATA_W-1:0] pc8;
    logic [DATA_W-1:0] ao;
    logic [DATA_W-1:0] dm;
    logic [DATA_W-1:0] instr;

    modport master (
        output valid, a3, pc8, ao, dm, instr,
        input  ready
    );

    modport slave (
        input  valid, a3, pc8, ao, dm, instr,
        output ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Purpose: pipeline stage register for the a3/pc8/ao/dm/instr bundle with a
//   valid/ready handshake, a 2-entry skid buffer (main + skid), synchronous
//   flush and a count of retired output transfers.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   flush      synchronous kill of every buffered entry
//   up         slave side of the upstream bundle (up.ready is in_ready)
//   dn         master side of the downstream bundle (dn.valid is out_valid)
//   occupancy  entries held: 0, 1 or 2
//   retire_cnt completed output transfers, wraps modulo 2^CNT_W
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int A3_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    pipe_stage_skid_if.slave         up,
    pipe_stage_skid_if.master        dn,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int PW = A3_W + 4 * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [PW-1:0]     main_reg;
    logic [PW-1:0]     skid_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [CNT_W-1:0]  retire_cnt_reg;

    logic              push;
    logic              pop;
    logic [PW-1:0]     in_bundle;

    assign in_bundle = {up.a3, up.pc8, up.ao, up.dm, up.instr};
    assign push      = up.valid & in_ready_reg;
    assign pop       = out_valid_reg & dn.ready;

    // Main holds the oldest entry; the skid register only ever feeds main,
    // so ordering stays FIFO. Main is cleared whenever it becomes invalid,
    // which keeps the output payload at zero for bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= EMPTY;
            main_reg       <= '0;
            skid_reg       <= '0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            retire_cnt_reg <= '0;
        end else begin
            // A pop coincident with flush still counts: downstream took it.
            if (pop) begin
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            end

            if (flush) begin
                state_reg     <= EMPTY;
                main_reg      <= '0;
                skid_reg      <= '0;
                in_ready_reg  <= 1'b1;
                out_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (push) begin
                            state_reg     <= ONE;
                            main_reg      <= in_bundle;
                            out_valid_reg <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_reg <= in_bundle;
                        end else if (push) begin
                            state_reg    <= FULL;
                            skid_reg     <= in_bundle;
                            in_ready_reg <= 1'b0;
                        end else if (pop) begin
                            state_reg     <= EMPTY;
                            main_reg      <= '0;
                            out_valid_reg <= 1'b0;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so no push can arrive.
                        if (pop) begin
                            state_reg    <= ONE;
                            main_reg     <= skid_reg;
                            skid_reg     <= '0;
                            in_ready_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg     <= EMPTY;
                        main_reg      <= '0;
                        skid_reg      <= '0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign up.ready   = in_ready_reg;
    assign dn.valid   = out_valid_reg;
    assign {dn.a3, dn.pc8, dn.ao, dn.dm, dn.instr} = main_reg;
    assign occupancy  = state_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule
